// File: rtl/weight_bank_streamer_if.sv
// Weight-bank streamer bus: word write port, stream command/status and the
// beat-wide read stream toward the MAC array.
interface weight_bank_streamer_if #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 98,
  parameter int ROW_LEN  = 784,
  parameter int NUM_ROWS = 200
);
  localparam int BEATS  = ROW_LEN / LANES;
  localparam int MEM_AW = (NUM_ROWS * ROW_LEN > 1) ? $clog2(NUM_ROWS * ROW_LEN) : 1;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                    wr_en;
  logic [MEM_AW-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_drop;
  logic                    start;
  logic [ROW_W-1:0]        start_row;
  logic                    busy;
  logic                    err_row;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [LANES*DATA_W-1:0] rd_data;
  logic [BEAT_W-1:0]       rd_beat;
  logic                    rd_last;
  logic                    done;

  // Loader / consumer side.
  modport master (
    output wr_en, wr_addr, wr_data, start, start_row, rd_ready,
    input  wr_drop, busy, err_row, rd_valid, rd_data, rd_beat, rd_last, done
  );

  // Weight bank side.
  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_row, rd_ready,
    output wr_drop, busy, err_row, rd_valid, rd_data, rd_beat, rd_last, done
  );
endinterface

// File: rtl/weight_bank_streamer.sv
// Weight bank: NUM_ROWS x ROW_LEN words loaded one word per cycle, streamed
// out one row at a time as BEATS beats of LANES words with valid/ready.
// A registered read feeds a one-entry prefetch buffer ahead of the output
// register, so beats flow every cycle and survive arbitrary backpressure.
module weight_bank_streamer #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 98,
  parameter int ROW_LEN  = 784,
  parameter int NUM_ROWS = 200
) (
  input logic                   clk,
  input logic                   rst_n,
  weight_bank_streamer_if.slave bus
);
  localparam int BEATS  = ROW_LEN / LANES;
  localparam int DEPTH  = NUM_ROWS * ROW_LEN;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [MEM_AW:0]     DEPTH_C   = (MEM_AW + 1)'(DEPTH);
  localparam logic [ROW_W:0]      ROWS_C    = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [MEM_AW-1:0]   ROW_LEN_A = MEM_AW'(ROW_LEN);
  localparam logic [MEM_AW-1:0]   LANES_A   = MEM_AW'(LANES);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [ROW_W-1:0]        row_q;
  logic [BEAT_W-1:0]       fetch_beat;   // next beat to read from the array
  logic                    fetch_more;   // beats still left to read
  logic                    pf_valid;
  logic [BEAT_W-1:0]       pf_beat;
  logic [LANES*DATA_W-1:0] pf_data;
  logic                    wr_ok;
  logic                    hs;
  logic                    out_free;
  logic                    pf_load;
  logic [MEM_AW-1:0]       rd_base;

  assign wr_ok    = bus.wr_en && !bus.busy && ({1'b0, bus.wr_addr} < DEPTH_C);
  assign hs       = bus.rd_valid && bus.rd_ready;
  assign out_free = !bus.rd_valid || bus.rd_ready;
  // Read a new beat whenever the prefetch slot is (or is about to be) empty.
  assign pf_load  = (state == FETCH) ||
                    ((state == STREAM) && fetch_more && (!pf_valid || out_free));
  assign rd_base  = MEM_AW'(row_q) * ROW_LEN_A + MEM_AW'(fetch_beat) * LANES_A;

  // Word write port into the weight array.
  // NOTE: the array has no reset so it maps onto RAM and keeps its contents through rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Synchronous beat-wide read into the prefetch slot.
  always_ff @(posedge clk) begin
    if (pf_load) begin
      for (int l = 0; l < LANES; l++)
        pf_data[l*DATA_W +: DATA_W] <= mem[rd_base + MEM_AW'(l)];
    end
  end

  // Control FSM, prefetch bookkeeping and registered stream outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_q       <= '0;
      fetch_beat  <= '0;
      fetch_more  <= 1'b0;
      pf_valid    <= 1'b0;
      pf_beat     <= '0;
      bus.busy    <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_beat <= '0;
      bus.rd_last <= 1'b0;
      bus.done    <= 1'b0;
      bus.err_row <= 1'b0;
      bus.wr_drop <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.err_row <= 1'b0;
      bus.wr_drop <= bus.wr_en && !wr_ok;
      case (state)
        IDLE: begin
          // The done cycle still counts as busy for new commands.
          if (bus.start && !bus.done) begin
            if ({1'b0, bus.start_row} < ROWS_C) begin
              row_q      <= bus.start_row;
              fetch_beat <= '0;
              fetch_more <= 1'b1;
              bus.busy   <= 1'b1;
              state      <= FETCH;
            end else begin
              bus.err_row <= 1'b1;
            end
          end
        end
        FETCH: begin
          pf_valid   <= 1'b1;
          pf_beat    <= fetch_beat;
          fetch_beat <= fetch_beat + BEAT_W'(1);
          fetch_more <= (fetch_beat != LAST_BEAT);
          state      <= STREAM;
        end
        STREAM: begin
          if (hs && bus.rd_last) begin
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_beat  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            pf_valid     <= 1'b0;
            state        <= IDLE;
          end else begin
            if (out_free) begin
              if (pf_valid) begin
                bus.rd_valid <= 1'b1;
                bus.rd_data  <= pf_data;
                bus.rd_beat  <= pf_beat;
                bus.rd_last  <= (pf_beat == LAST_BEAT);
              end else begin
                bus.rd_valid <= 1'b0;
                bus.rd_data  <= '0;
                bus.rd_last  <= 1'b0;
              end
            end
            if (pf_load) begin
              pf_valid   <= 1'b1;
              pf_beat    <= fetch_beat;
              fetch_beat <= fetch_beat + BEAT_W'(1);
              fetch_more <= (fetch_beat != LAST_BEAT);
            end else if (out_free) begin
              pf_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_bank_streamer.sv
// Bench for weight_bank_streamer: a small configuration (4 lanes, 16-word
// rows, 3 rows) exercised with directed and random traffic, plus the default
// configuration streaming its last row. Expected beats are queued at command
// time from a word-array model; monitors pop them on every handshake.
module tb_weight_bank_streamer;
  localparam int S_LANES = 4, S_ROWLEN = 16, S_ROWS = 3, S_BEATS = 4, S_DEPTH = 48;
  localparam int D_LANES = 98, D_ROWLEN = 784, D_BEATS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  weight_bank_streamer_if #(.DATA_W(16), .LANES(S_LANES), .ROW_LEN(S_ROWLEN), .NUM_ROWS(S_ROWS)) sif ();
  weight_bank_streamer_if dif ();

  weight_bank_streamer #(.DATA_W(16), .LANES(S_LANES), .ROW_LEN(S_ROWLEN), .NUM_ROWS(S_ROWS)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(sif));
  weight_bank_streamer u_dflt (.clk(clk), .rst_n(rst_n), .bus(dif));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- small-config model and scoreboard ----------------
  typedef struct { logic [S_LANES*16-1:0] data; int beat; bit last; } s_exp_t;
  typedef struct { logic [D_LANES*16-1:0] data; int beat; bit last; } d_exp_t;

  int         s_mem [S_DEPTH];
  s_exp_t     s_q [$];
  d_exp_t     d_q [$];
  s_exp_t     se;
  d_exp_t     de;
  bit         s_stall = 0;
  logic [63:0] s_hold;
  int         s_hold_beat;
  logic [15:0] d_b0l0, d_b7l97;

  task automatic s_push(input int r);
    s_exp_t e;
    for (int b = 0; b < S_BEATS; b++) begin
      for (int l = 0; l < S_LANES; l++)
        e.data[l*16 +: 16] = 16'(s_mem[r*S_ROWLEN + b*S_LANES + l]);
      e.beat = b;
      e.last = (b == S_BEATS - 1);
      s_q.push_back(e);
    end
  endtask

  // Small-config monitor: beat order/content, stall stability, idle-zero data.
  always @(negedge clk) begin
    if (!rst_n) begin
      s_stall = 0;
    end else begin
      if (!sif.rd_valid) check("s_idle_data_zero", sif.rd_data, 64'd0);
      if (s_stall) begin
        check("s_hold_valid", sif.rd_valid, 1);
        check("s_hold_data", sif.rd_data, s_hold);
        check("s_hold_beat", sif.rd_beat, s_hold_beat);
      end
      if (sif.rd_valid && sif.rd_ready) begin
        check("s_beat_expected", s_q.size() != 0, 1);
        if (s_q.size() != 0) begin
          se = s_q.pop_front();
          check("s_beat_data", sif.rd_data, se.data);
          check("s_beat_index", sif.rd_beat, se.beat);
          check("s_beat_last", sif.rd_last, se.last);
        end
        s_stall = 0;
      end else if (sif.rd_valid) begin
        s_stall     = 1;
        s_hold      = sif.rd_data;
        s_hold_beat = sif.rd_beat;
      end else begin
        s_stall = 0;
      end
    end
  end

  // Default-config monitor: first mismatching lane of each beat is reported.
  always @(negedge clk) begin
    if (rst_n && dif.rd_valid && dif.rd_ready) begin
      check("d_beat_expected", d_q.size() != 0, 1);
      if (d_q.size() != 0) begin
        int cl;
        de = d_q.pop_front();
        cl = 0;
        for (int l = D_LANES - 1; l >= 0; l--)
          if (dif.rd_data[l*16 +: 16] !== de.data[l*16 +: 16]) cl = l;
        check($sformatf("d_data_lane%0d", cl), dif.rd_data[cl*16 +: 16], de.data[cl*16 +: 16]);
        check("d_beat_index", dif.rd_beat, de.beat);
        check("d_beat_last", dif.rd_last, de.last);
        if (de.beat == 0) d_b0l0 = dif.rd_data[15:0];
        if (de.beat == D_BEATS - 1) d_b7l97 = dif.rd_data[(D_LANES-1)*16 +: 16];
      end
    end
  end

  // One word write while idle; returns just after the sampling edge.
  task automatic s_write(input int a, input int d);
    sif.wr_en   = 1'b1;
    sif.wr_addr = 6'(a);
    sif.wr_data = 16'(d);
    @(posedge clk); #1;
    sif.wr_en = 1'b0;
    if (a < S_DEPTH) s_mem[a] = d;
  endtask

  // Stream one row. mode 0: ready high, 1: ready 1,0,0 repeating, 2: random.
  // poke: drop a write and ignore a start mid-stream. sim_wr >= 0: write the
  // row's first word in the start cycle.
  task automatic s_stream(input int r, input int mode, input bit poke, input int sim_wr, input string tag);
    int first_v = 0, last_acc = -1, done_k = 0;
    sif.start     = 1'b1;
    sif.start_row = 2'(r);
    if (sim_wr >= 0) begin
      sif.wr_en   = 1'b1;
      sif.wr_addr = 6'(r * S_ROWLEN);
      sif.wr_data = 16'(sim_wr);
      s_mem[r * S_ROWLEN] = sim_wr;
    end
    s_push(r);
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.wr_en = 1'b0;
    check({tag, "_busy_rise"}, sif.busy, 1);
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      case (mode)
        0:       sif.rd_ready = 1'b1;
        1:       sif.rd_ready = ((k - 1) % 3 == 0);
        default: sif.rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke && k == 1) begin
        sif.wr_en = 1'b1; sif.wr_addr = 6'd0; sif.wr_data = 16'hBEEF;
      end
      if (poke && k == 3) begin
        sif.start = 1'b1; sif.start_row = 2'd2;
      end
      if (sif.rd_valid && sif.rd_ready) last_acc = k - 1;
      @(posedge clk); #1;
      if (poke && k == 1) begin
        sif.wr_en = 1'b0;
        check({tag, "_busy_wr_drop"}, sif.wr_drop, 1);
      end
      if (poke && k == 3) sif.start = 1'b0;
      if (sif.rd_valid && first_v == 0) first_v = k;
      if (sif.done) done_k = k;
    end
    check({tag, "_first_valid_cycle"}, first_v, 2);
    check({tag, "_done_after_last_accept"}, done_k, last_acc + 1);
    if (mode == 0) check({tag, "_done_cycle"}, done_k, S_BEATS + 2);
    check({tag, "_end_outputs_low"}, {sif.busy, sif.rd_valid, sif.rd_last}, 0);
    sif.start     = 1'b1;
    sif.start_row = 2'd0;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check({tag, "_start_in_done_ignored"}, {sif.busy, sif.rd_valid}, 0);
    check({tag, "_queue_drained"}, s_q.size(), 0);
  endtask

  initial begin
    bit any_done;
    bit d_done;
    rst_n = 1'b0;
    sif.wr_en = 0; sif.wr_addr = '0; sif.wr_data = '0; sif.start = 0; sif.start_row = '0; sif.rd_ready = 0;
    dif.wr_en = 0; dif.wr_addr = '0; dif.wr_data = '0; dif.start = 0; dif.start_row = '0; dif.rd_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", sif.busy, 0);
    check("rst_rd_valid", sif.rd_valid, 0);
    check("rst_rd_data", sif.rd_data, 0);
    check("rst_flags", {sif.rd_beat, sif.rd_last, sif.done, sif.err_row, sif.wr_drop}, 0);
    rst_n = 1'b1;

    // Fill word a = a + 1.
    for (int a = 0; a < S_DEPTH; a++) begin
      s_write(a, a + 1);
      if (a == 0) check("fill_no_drop", sif.wr_drop, 0);
    end

    s_stream(1, 0, 0, -1, "row1_full_rate");
    s_stream(2, 1, 0, -1, "row2_backpressure");

    // Out-of-range row and address.
    sif.start = 1'b1; sif.start_row = 2'd3;
    @(posedge clk); #1;
    sif.start = 1'b0;
    check("bad_row_err_pulse", sif.err_row, 1);
    check("bad_row_not_busy", sif.busy, 0);
    @(posedge clk); #1;
    check("bad_row_err_clears", sif.err_row, 0);
    check("bad_row_no_valid", sif.rd_valid, 0);
    s_write(48, 16'h1234);
    check("bad_addr_drop", sif.wr_drop, 1);
    @(posedge clk); #1;
    check("bad_addr_drop_clears", sif.wr_drop, 0);

    s_stream(0, 0, 1, -1, "row0_poke");
    s_stream(2, 0, 0, -1, "row2_intact");

    // Reset while beat 2 is on the bus.
    s_push(0);
    sif.start = 1'b1; sif.start_row = 2'd0; sif.rd_ready = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_beat2", sif.rd_beat, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid_busy_last", {sif.busy, sif.rd_valid, sif.rd_last}, 0);
    check("mid_rst_data", sif.rd_data, 0);
    check("mid_rst_misc", {sif.rd_beat, sif.done, sif.err_row, sif.wr_drop}, 0);
    s_q.delete();
    rst_n = 1'b1;
    any_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      any_done |= sif.done;
    end
    check("mid_rst_no_done", any_done, 0);
    s_stream(0, 2, 0, -1, "row0_after_rst");

    // Random rewrites, rows, backpressure and write-with-start.
    for (int it = 0; it < 20; it++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) s_write($urandom_range(0, S_DEPTH - 1), $urandom_range(0, 65535));
      s_stream($urandom_range(0, S_ROWS - 1), 2, 0,
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : -1, "rand");
    end

    // Default configuration: fill row 199 with word a = a[15:0] and stream it.
    for (int a = 199 * D_ROWLEN; a < 200 * D_ROWLEN; a++) begin
      dif.wr_en = 1'b1; dif.wr_addr = 18'(a); dif.wr_data = 16'(a);
      @(posedge clk); #1;
    end
    dif.wr_en = 1'b0;
    for (int b = 0; b < D_BEATS; b++) begin
      d_exp_t e;
      for (int l = 0; l < D_LANES; l++) e.data[l*16 +: 16] = 16'(199 * D_ROWLEN + b * D_LANES + l);
      e.beat = b;
      e.last = (b == D_BEATS - 1);
      d_q.push_back(e);
    end
    dif.start = 1'b1; dif.start_row = 8'd199;
    @(posedge clk); #1;
    dif.start = 1'b0;
    d_done = 0;
    for (int k = 0; k < 300 && !d_done; k++) begin
      dif.rd_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (dif.done) d_done = 1;
    end
    check("d_done_seen", d_done, 1);
    check("d_beat0_lane0", d_b0l0, 16'd24944);
    check("d_beat7_lane97", d_b7l97, 16'd25727);
    check("d_queue_drained", d_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/weight_bank_streamer.md
Name: weight_bank_streamer

Overview:
Parametrised successor to the layer-1 weight SRAM. Holds NUM_ROWS x ROW_LEN fixed-point weights, loaded through a word-wide write port rather than a file preload. On a start command it streams one full neuron row to the MAC array as ROW_LEN/LANES beats of LANES words each, under a valid/ready handshake with backpressure. Sits between the weight loader and the layer datapath, and serves any layer by re-parametrisation.

Parameters:
DATA_W, 16, bits per weight word (fixed-point)
LANES, 98, words delivered per beat
ROW_LEN, 784, words per row (inputs per neuron); ROW_LEN % LANES must be 0
NUM_ROWS, 200, rows stored (neurons)
BEATS, ROW_LEN/LANES (8 at defaults), derived; beats per row
MEM_AW, clog2(NUM_ROWS*ROW_LEN), derived word-address width
ROW_W, clog2(NUM_ROWS) (min 1), derived row-index width
BEAT_W, clog2(BEATS) (min 1), derived beat-index width

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write strobe, one word per cycle
wr_addr  in  MEM_AW  0-based word address
wr_data  in  DATA_W  write data
wr_drop  out  1  one-cycle pulse: write ignored (busy or address out of range)
start  in  1  one-cycle stream request
start_row  in  ROW_W  0-based row to stream
busy  out  1  stream in progress
err_row  out  1  one-cycle pulse: start_row >= NUM_ROWS
rd_valid  out  1  beat available
rd_ready  in  1  consumer accepts beat
rd_data  out  LANES*DATA_W  lane l in bits [l*DATA_W +: DATA_W]; lane 0 at LSBs
rd_beat  out  BEAT_W  index of the current beat
rd_last  out  1  high with the final beat of a row
done  out  1  one-cycle pulse after the last beat handshake

Behaviour:
- Mapping: word a is row a/ROW_LEN. Beat b, lane l of row r is word r*ROW_LEN + b*LANES + l. No 1-based offsets.
- Reset (rst_n=0 at a rising edge): FSM to IDLE. busy, rd_valid, rd_last, done, err_row and wr_drop go to 0; rd_data and rd_beat go to 0. Memory contents are retained. Reset mid-stream aborts the stream with no done pulse.
- FSM states: IDLE, FETCH, STREAM.
- IDLE: start with start_row < NUM_ROWS is accepted, latches the row, and goes to FETCH; busy rises next cycle. start with start_row >= NUM_ROWS pulses err_row next cycle and stays in IDLE.
- FETCH: issues the synchronous read of beat 0, then goes to STREAM.
- STREAM: rd_valid rises at T+2, where T is the start-accept edge.
- Throughput: with rd_ready held high, beats 0..BEATS-1 appear on consecutive cycles T+2..T+1+BEATS. A prefetch plus one-entry skid buffer is required.
- Handshake: a beat transfers when rd_valid && rd_ready. While rd_valid && !rd_ready, rd_data, rd_beat and rd_last hold stable. No beat is lost or duplicated under any rd_ready pattern.
- rd_last = rd_valid && rd_beat == BEATS-1.
- After the last handshake: rd_valid, busy and rd_last fall the next cycle, done pulses that same cycle, and the FSM returns to IDLE.
- rd_data is all-zero whenever rd_valid=0.
- start while busy (including the done cycle) is ignored, with no error.
- Writes: accepted only when busy=0 and wr_addr < NUM_ROWS*ROW_LEN; the word updates at that edge. Otherwise the write is dropped and wr_drop pulses next cycle.
- Simultaneous start and wr_en in IDLE: the write completes at that edge and the stream sees the new data.
- BEATS=1: a single beat with rd_last=1.

Test Plan:
- LANES=4, ROW_LEN=16, NUM_ROWS=3. Write word a = a+1 for a=0..47, then start row 1 with rd_ready=1 -> 4 consecutive beats from T+2; beat0 lanes = 17,18,19,20; beat3 lanes = 29..32 with rd_last=1; done at T+6.
- Same fill, start row 2, rd_ready toggling 1,0,0,1,... -> data held while stalled; lane sequence exactly 33..48, each beat once; done 1 cycle after the final accept.
- start_row=3 -> err_row pulses, busy stays 0, no rd_valid. Then wr_en at wr_addr=48 -> wr_drop pulses, memory unchanged.
- wr_en to word 0 while streaming row 0 -> wr_drop; streamed beat0 lane0 = 1 (old value). A new start issued mid-stream is ignored.
- rst_n low at beat 2 of a stream -> next cycle all outputs 0 and no done. After reset, start row 0 -> data still 1..16 (memory retained).
- Defaults (98/784/200): fill word a = a[15:0], stream row 199 -> 8 beats; beat0 lane0 = 156016 mod 65536 = 24944; beat7 lane97 = 156799 mod 65536 = 25727.
